// File: rtl/key_priority_encoder_if.sv
// Key encoder bus: active-low key lines and ack in, encoded code/valid/busy out.
// The encoder side uses the master modport, the consumer/key side uses slave.
interface key_priority_encoder_if;
  logic [7:0] key_n;
  logic       code_ack;
  logic [2:0] code;
  logic       code_valid;
  logic       busy;

  modport master (
    input  key_n,
    input  code_ack,
    output code,
    output code_valid,
    output busy
  );

  modport slave (
    output key_n,
    output code_ack,
    input  code,
    input  code_valid,
    input  busy
  );
endinterface

// File: rtl/key_priority_encoder.sv
// Debounced 8-to-3 priority encoder for active-low keys with a valid/ack handshake.
// Optional auto-repeat of held keys: define KEY_PRIORITY_ENCODER_AUTO_REPEAT_EN.
module key_priority_encoder #(
  parameter int unsigned DEB_CYCLES    = 4,
  parameter int unsigned REPEAT_CYCLES = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  key_priority_encoder_if.master kbd
);

  typedef enum logic [1:0] {StIdle, StDebounce, StValid, StRelease} state_e;

  localparam logic [15:0] DebLast = 16'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 2 || DEB_CYCLES > 65535) begin : gen_deb_range_check
    $error("DEB_CYCLES out of range");
  end
  if (REPEAT_CYCLES < 1) begin : gen_rep_range_check
    $error("REPEAT_CYCLES must be at least 1");
  end

  state_e      state_q, state_d;
  logic [7:0]  sync1_q, sync2_q;
  logic [7:0]  snap_q, snap_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic [7:0]  act;

  assign act = ~sync2_q;

  function automatic logic [2:0] encode(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    // Ascending scan so the highest set bit overwrites lower ones.
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

`ifdef KEY_PRIORITY_ENCODER_AUTO_REPEAT_EN
  localparam logic [31:0] RepLast = 32'(REPEAT_CYCLES - 1);
  logic [31:0] rcnt_q, rcnt_d;
`endif

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = valid_q;
`ifdef KEY_PRIORITY_ENCODER_AUTO_REPEAT_EN
    rcnt_d  = rcnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (act != 8'h00) begin
          snap_d  = act;
          cnt_d   = 16'd1;
          state_d = StDebounce;
        end
      end
      StDebounce: begin
        if (act == 8'h00) begin
          cnt_d   = 16'd0;
          state_d = StIdle;
        end else if (act != snap_q) begin
          snap_d = act;
          cnt_d  = 16'd1;
        end else if (cnt_q == DebLast) begin
          code_d  = encode(snap_q);
          valid_d = 1'b1;
          state_d = StValid;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StValid: begin
        if (kbd.code_ack) begin
          valid_d = 1'b0;
          cnt_d   = 16'd0;
`ifdef KEY_PRIORITY_ENCODER_AUTO_REPEAT_EN
          rcnt_d  = 32'd0;
`endif
          state_d = StRelease;
        end
      end
      StRelease: begin
        // cnt tracks consecutive all-released cycles; any held key restarts it.
        if (act == 8'h00) begin
          if (cnt_q == DebLast) begin
            cnt_d   = 16'd0;
            state_d = StIdle;
          end else if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
        end else begin
          cnt_d = 16'd0;
        end
`ifdef KEY_PRIORITY_ENCODER_AUTO_REPEAT_EN
        // snap_q is never zero here, so this cannot collide with the release exit.
        if (act == snap_q) begin
          if (rcnt_q == RepLast) begin
            rcnt_d  = 32'd0;
            valid_d = 1'b1;
            state_d = StValid;
          end else if (rcnt_q != 32'hFFFF_FFFF) begin
            rcnt_d = rcnt_q + 32'd1;
          end
        end else begin
          rcnt_d = 32'd0;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 8'hFF;
      sync2_q <= 8'hFF;
      state_q <= StIdle;
      snap_q  <= 8'h00;
      cnt_q   <= 16'd0;
      code_q  <= 3'b000;
      valid_q <= 1'b0;
    end else begin
      sync1_q <= kbd.key_n;
      sync2_q <= sync1_q;
      state_q <= state_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

`ifdef KEY_PRIORITY_ENCODER_AUTO_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q <= 32'd0;
    end else begin
      rcnt_q <= rcnt_d;
    end
  end
`endif

  assign kbd.code       = code_q;
  assign kbd.code_valid = valid_q;
  assign kbd.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_key_priority_encoder.sv
// Bench for key_priority_encoder: event-level reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_key_priority_encoder;
  localparam int unsigned DEB = 4;
  localparam int unsigned REP = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   edge_cnt = 0;

  key_priority_encoder_if kbd ();

  key_priority_encoder #(
    .DEB_CYCLES    (DEB),
    .REPEAT_CYCLES (REP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kbd   (kbd.master)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: keys seen through two register delays; an event fires when the
  // same nonzero pattern has been seen DEB times in a row while armed.
  localparam int ModeArmed   = 0;
  localparam int ModePending = 1;
  localparam int ModeRelease = 2;

  logic [7:0] m_k1 = 8'hFF, m_k2 = 8'hFF, m_prev = 8'h00, m_snap = 8'h00;
  logic [2:0] m_code = 3'b000;
  int         m_mode = ModeArmed;
  int         m_run = 0, m_zrun = 0, m_hrun = 0;

  function automatic logic [2:0] top_key(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) return 3'(i);
    end
    return 3'b000;
  endfunction

  initial forever begin
    logic [7:0] a;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_k1 = 8'hFF; m_k2 = 8'hFF; m_prev = 8'h00; m_snap = 8'h00;
      m_code = 3'b000; m_mode = ModeArmed; m_run = 0; m_zrun = 0; m_hrun = 0;
    end else begin
      a    = ~m_k2;
      m_k2 = m_k1;
      m_k1 = kbd.key_n;
      if (m_mode == ModeArmed) begin
        if (a == 8'h00) m_run = 0;
        else m_run = (a == m_prev && m_run > 0) ? m_run + 1 : 1;
        if (m_run == int'(DEB)) begin
          m_mode = ModePending;
          m_snap = a;
          m_code = top_key(a);
          m_run  = 0;
        end
      end else if (m_mode == ModePending) begin
        if (kbd.code_ack) begin
          m_mode = ModeRelease;
          m_zrun = 0;
          m_hrun = 0;
        end
      end else begin
        m_zrun = (a == 8'h00) ? m_zrun + 1 : 0;
        if (m_zrun == int'(DEB)) begin
          m_mode = ModeArmed;
          m_run  = 0;
        end
`ifdef KEY_PRIORITY_ENCODER_AUTO_REPEAT_EN
        m_hrun = (a == m_snap) ? m_hrun + 1 : 0;
        if (m_hrun == int'(REP)) begin
          m_mode = ModePending;
          m_hrun = 0;
        end
`endif
      end
      m_prev = a;
    end
  end

  initial forever begin
    @(negedge clk);
    check("model_code", 32'(kbd.code), 32'(m_code));
    check("model_valid", 32'(kbd.code_valid), 32'(m_mode == ModePending));
    check("model_busy", 32'(kbd.busy), 32'(!(m_mode == ModeArmed && m_run == 0)));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_keys(input logic [7:0] v);
    @(negedge clk);
    kbd.key_n = v;
  endtask

  task automatic do_ack();
    @(negedge clk);
    kbd.code_ack = 1'b1;
    @(negedge clk);
    kbd.code_ack = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int max_edges);
    logic got;
    got = 1'b0;
    for (int i = 0; i < max_edges; i++) begin
      @(posedge clk);
      #1;
      if (kbd.code_valid) begin
        got = 1'b1;
        break;
      end
    end
    check(name, 32'(got), 32'd1);
  endtask

  task automatic release_all();
    set_keys(8'hFF);
    tick(int'(DEB) + 6);
  endtask

  int t_prev;

  initial begin
    kbd.key_n    = 8'h00;
    kbd.code_ack = 1'b0;
    #1 rst_n = 1'b0;

    // Reset with all keys held
    tick(3);
    check("rst_code", 32'(kbd.code), 32'd0);
    check("rst_valid", 32'(kbd.code_valid), 32'd0);
    check("rst_busy", 32'(kbd.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1 check("busy_after_rst", 32'(kbd.busy), 32'(e == 3));
    end
    wait_valid("all_keys_valid", 10);
    check("all_keys_code", 32'(kbd.code), 32'd7);
    do_ack();
    release_all();

    // Key 2: valid exactly on edge 6, held without ack
    set_keys(8'b1111_1011);
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1 check("k2_latency", 32'(kbd.code_valid), 32'(e == 6));
    end
    check("k2_code", 32'(kbd.code), 32'd2);
    tick(14);
    check("k2_hold_valid", 32'(kbd.code_valid), 32'd1);
    check("k2_hold_code", 32'(kbd.code), 32'd2);
    do_ack();
    check("k2_ack_drop", 32'(kbd.code_valid), 32'd0);
    check("k2_code_kept", 32'(kbd.code), 32'd2);
    release_all();

    // Priority: keys 7+0, then keys 3+0
    set_keys(8'b0111_1110);
    wait_valid("k70_valid", 10);
    check("k70_code", 32'(kbd.code), 32'd7);
    do_ack();
    release_all();
    set_keys(8'b1111_0110);
    wait_valid("k30_valid", 10);
    check("k30_code", 32'(kbd.code), 32'd3);
    do_ack();
    release_all();

    // Bouncing key 3 never qualifies, then a steady press does
    for (int i = 0; i < 10; i++) begin
      set_keys((i % 2 == 0) ? 8'hF7 : 8'hFF);
      tick(1);
      check("bounce_no_valid", 32'(kbd.code_valid), 32'd0);
    end
    set_keys(8'hF7);
    wait_valid("k3_valid", 10);
    check("k3_code", 32'(kbd.code), 32'd3);
    do_ack();
    release_all();

    // Adding a key without a full release yields no new event
    set_keys(8'hFB);
    wait_valid("k2b_valid", 10);
    do_ack();
    set_keys(8'hBB);
    tick(20);
    check("no_second_event", 32'(kbd.code_valid), 32'd0);
    release_all();
    set_keys(8'hBF);
    wait_valid("k6_valid", 10);
    check("k6_code", 32'(kbd.code), 32'd6);
    do_ack();
    release_all();

    // Asynchronous reset during VALID, then the held key counts as a fresh press
    set_keys(8'hDF);
    wait_valid("k5_valid", 10);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(kbd.code_valid), 32'd0);
    check("async_rst_busy", 32'(kbd.busy), 32'd0);
    check("async_rst_code", 32'(kbd.code), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1 check("k5_fresh_latency", 32'(kbd.code_valid), 32'(e == 6));
    end
    check("k5_code", 32'(kbd.code), 32'd5);
    t_prev = edge_cnt;
`ifdef KEY_PRIORITY_ENCODER_AUTO_REPEAT_EN
    for (int r = 0; r < 3; r++) begin
      do_ack();
      wait_valid("repeat_valid", int'(REP) + 4);
      check("repeat_period", 32'(edge_cnt - t_prev), 32'(REP + 1));
      check("repeat_code", 32'(kbd.code), 32'd5);
      t_prev = edge_cnt;
    end
`else
    do_ack();
    tick(40);
    check("single_event", 32'(kbd.code_valid), 32'd0);
    check("single_code_kept", 32'(kbd.code), 32'd5);
`endif
    do_ack();
    release_all();
    check("final_idle", 32'(kbd.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end
endmodule
